// File: rtl/frame_update_arbiter.sv
// Round-robin arbiter that grants sprite-state update slots during vertical blanking.
// Optional grant timeout is built when FRAME_UPDATE_TIMEOUT_EN is defined.
module frame_update_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int VIS_LINES     = 480,
  parameter int GRANT_TIMEOUT = 800
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hor_count,
  input  logic [9:0]         ver_count,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic               overrun_clr,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               frame_tick,
  output logic [7:0]         frame_count,
  output logic               overrun
);

  localparam int          PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR      = NUM_REQ;
  localparam logic [9:0]  VIS_L   = 10'(VIS_LINES);
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

  if (NUM_REQ < 1 || GRANT_TIMEOUT < 1) begin : g_param_check
    $error("frame_update_arbiter: NUM_REQ and GRANT_TIMEOUT must be positive");
  end

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t              state, state_nx;
  logic [PW-1:0]       ptr, ptr_nx;
  logic [NUM_REQ-1:0]  grant_nx;
  logic                ov_set;
  logic                window_open;
  logic                tick_cond;
  logic                sel_valid;
  logic [PW-1:0]       sel_idx;
  logic [PW-1:0]       cand;
  logic                timeout_hit;

  assign window_open = (ver_count >= VIS_L);
  assign tick_cond   = (ver_count == VIS_L) && (hor_count == 10'd0);
  assign busy        = |grant;

`ifdef FRAME_UPDATE_TIMEOUT_EN
  localparam int            TW      = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(GRANT_TIMEOUT - 1);

  logic [TW-1:0] to_cnt;

  // Held at zero outside GRANT so every grant starts counting from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               to_cnt <= '0;
    else if (state != GRANT) to_cnt <= '0;
    else                     to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == GRANT) && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Round-robin search starting just after the last granted index.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = ptr;
    cand      = ptr;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand = PW'((32'(ptr) + i) % NR);
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx   = ptr;
    ov_set   = 1'b0;
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (window_open) state_nx = ARB;
      end
      ARB: begin
        grant_nx = '0;
        if (!window_open) begin
          state_nx = IDLE;
        end else if (sel_valid) begin
          grant_nx[sel_idx] = 1'b1;
          ptr_nx            = sel_idx;
          state_nx          = GRANT;
        end
      end
      GRANT: begin
        // Window close outranks done; ptr holds the granted index.
        if (!window_open) begin
          grant_nx = '0;
          ov_set   = 1'b1;
          state_nx = IDLE;
        end else if (done[ptr]) begin
          grant_nx = '0;
          state_nx = ARB;
        end else if (timeout_hit) begin
          grant_nx = '0;
          ov_set   = 1'b1;
          state_nx = ARB;
        end
      end
      default: begin
        grant_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= PTR_RST;
      overrun     <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      ptr        <= ptr_nx;
      overrun    <= ov_set | (overrun & ~overrun_clr);
      frame_tick <= tick_cond;
      if (tick_cond) frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_update_arbiter.sv
// Bench for frame_update_arbiter: vector table, directed corner sequences and
// randomized traffic against an owner/queue-level reference model.
module tb_frame_update_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] hor_count = '0;
  logic [9:0] ver_count = '0;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic       overrun_clr = 1'b0;
  logic [3:0] grant;
  logic       busy;
  logic       frame_tick;
  logic [7:0] frame_count;
  logic       overrun;

  int checks = 0;
  int errors = 0;

`ifdef FRAME_UPDATE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  frame_update_arbiter #(
    .NUM_REQ(4),
    .VIS_LINES(480),
    .GRANT_TIMEOUT(800)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hor_count(hor_count),
    .ver_count(ver_count),
    .req(req),
    .done(done),
    .overrun_clr(overrun_clr),
    .grant(grant),
    .busy(busy),
    .frame_tick(frame_tick),
    .frame_count(frame_count),
    .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the slot, whether arbitration is armed, last winner.
  int m_owner, m_last, m_held, m_cnt;
  bit m_armed, m_ov, m_tick;
  bit model_on = 1'b0;

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_held = 0; m_cnt = 0;
    m_armed = 1'b0; m_ov = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_step();
    bit win, set, found;
    int c;
    win   = (ver_count >= 10'd480);
    set   = 1'b0;
    found = 1'b0;
    m_tick = (ver_count == 10'd480) && (hor_count == 10'd0);
    if (m_tick) m_cnt = (m_cnt + 1) % 256;
    if (m_owner >= 0) begin
      if (!win) begin
        m_owner = -1; m_armed = 1'b0; set = 1'b1;
      end else if (done[m_owner]) begin
        m_owner = -1; m_armed = 1'b1;
      end else if (TO_EN && m_held == 799) begin
        m_owner = -1; m_armed = 1'b1; set = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_armed) begin
      if (!win) m_armed = 1'b0;
      else begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (!found && req[c]) begin
            found = 1'b1; m_owner = c; m_last = c; m_held = 0;
          end
        end
      end
    end else if (win) begin
      m_armed = 1'b1;
    end
    if (set) m_ov = 1'b1;
    else if (overrun_clr) m_ov = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (model_on) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; done = '0; overrun_clr = 1'b0;
    ver_count = '0; hor_count = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [9:0] ver;
    logic [9:0] hor;
    logic [3:0] rq;
    logic [3:0] dn;
    logic       clr;
    logic [3:0] g;
    logic       t;
    logic [7:0] cnt;
    logic       ov;
  } vec_t;

  vec_t       tbl[9];
  logic [3:0] rr_exp[5];
  logic [3:0] mg;
  int         n;

  initial begin
    tbl[0] = '{10'd479, 10'd5, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0};
    tbl[1] = '{10'd480, 10'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'd1, 1'b0};
    tbl[2] = '{10'd480, 10'd1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 8'd1, 1'b0};
    tbl[3] = '{10'd480, 10'd2, 4'b0100, 4'b0001, 1'b0, 4'b0100, 1'b0, 8'd1, 1'b0};
    tbl[4] = '{10'd480, 10'd3, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 8'd1, 1'b0};
    tbl[5] = '{10'd480, 10'd4, 4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b0, 8'd1, 1'b0};
    tbl[6] = '{10'd480, 10'd5, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 8'd1, 1'b0};
    tbl[7] = '{10'd480, 10'd6, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 8'd1, 1'b0};
    tbl[8] = '{10'd480, 10'd7, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd1, 1'b0};
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Asynchronous reset values before any clock edge.
    #3 reset = 1'b1;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tick", 32'(frame_tick), 0);
    check("rst_count", 32'(frame_count), 0);
    check("rst_overrun", 32'(overrun), 0);

    // Vector table: frame tick, selective done, req drop while granted.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ver_count = tbl[i].ver; hor_count = tbl[i].hor;
      req = tbl[i].rq; done = tbl[i].dn; overrun_clr = tbl[i].clr;
      step();
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(|tbl[i].g));
      check($sformatf("vec%0d_tick", i), 32'(frame_tick), 32'(tbl[i].t));
      check($sformatf("vec%0d_count", i), 32'(frame_count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].ov));
    end

    // Round-robin order with all requesters active.
    do_reset();
    ver_count = 10'd490; hor_count = 10'd100; req = 4'b1111;
    step();
    check("rr_arb_entry", 32'(grant), 0);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (grant == 4'b0000 && n < 10) begin
        step();
        n++;
      end
      check($sformatf("rr%0d_grant", k), 32'(grant), 32'(rr_exp[k]));
      check($sformatf("rr%0d_gap", k), n, 1);
      step(); step();
      done = grant;
      step();
      done = '0;
      check($sformatf("rr%0d_release", k), 32'(grant), 0);
    end

    // Window close while granted, IDLE re-entry, overrun set vs clear.
    do_reset();
    ver_count = 10'd524; hor_count = 10'd10; req = 4'b0001;
    step(); step();
    check("wrap_grant", 32'(grant), 32'b0001);
    ver_count = 10'd0;
    step();
    check("wrap_revoke", 32'(grant), 0);
    check("wrap_overrun", 32'(overrun), 1);
    step();
    check("wrap_closed", 32'(grant), 0);
    ver_count = 10'd490;
    step();
    check("wrap_idle_to_arb", 32'(grant), 0);
    step();
    check("wrap_regrant", 32'(grant), 32'b0001);
    overrun_clr = 1'b1; ver_count = 10'd0;
    step();
    overrun_clr = 1'b0;
    check("clr_vs_set_overrun", 32'(overrun), 1);
    check("clr_vs_set_grant", 32'(grant), 0);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("clr_overrun", 32'(overrun), 0);

    // Grant held without done.
    do_reset();
    ver_count = 10'd490; hor_count = 10'd100; req = 4'b0001;
    step(); step();
    check("to_grant", 32'(grant), 32'b0001);
    n = 1;
    while (grant != 4'b0000 && n < 1000) begin
      step();
      if (grant != 4'b0000) n++;
    end
`ifdef FRAME_UPDATE_TIMEOUT_EN
    check("to_held_cycles", n, 800);
    check("to_grant_cleared", 32'(grant), 0);
    check("to_overrun", 32'(overrun), 1);
    step();
    check("to_rearb_grant", 32'(grant), 32'b0001);
`else
    check("hold_cycles", n, 1000);
    check("hold_grant", 32'(grant), 32'b0001);
    check("hold_overrun", 32'(overrun), 0);
    ver_count = 10'd0;
    step();
    check("hold_close_grant", 32'(grant), 0);
    check("hold_close_overrun", 32'(overrun), 1);
`endif

    // 256 frames wrap the frame counter.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      ver_count = 10'd480; hor_count = 10'd0;
      step();
      check("frame_tick_high", 32'(frame_tick), 1);
      hor_count = 10'd1;
      step();
      check("frame_tick_low", 32'(frame_tick), 0);
      if (f == 0) check("frame_count_first", 32'(frame_count), 1);
    end
    check("frame_count_wrap", 32'(frame_count), 0);

    // Reset in the middle of a grant with overrun already set.
    do_reset();
    ver_count = 10'd490; hor_count = 10'd100; req = 4'b0010;
    step(); step();
    check("mid_grant", 32'(grant), 32'b0010);
    ver_count = 10'd0;
    step();
    ver_count = 10'd490;
    step(); step();
    check("mid_regrant", 32'(grant), 32'b0010);
    check("mid_overrun_set", 32'(overrun), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    reset = 1'b0; req = 4'b1010;
    step(); step();
    check("post_rst_first", 32'(grant), 32'b0010);

    // Randomized traffic against the reference model.
    do_reset();
    model_on = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ($urandom % 16)
        0:       ver_count = 10'($urandom_range(0, 479));
        1:       ver_count = 10'd480;
        default: ver_count = 10'($urandom_range(480, 524));
      endcase
      hor_count   = 10'($urandom_range(0, 3));
      req         = 4'($urandom);
      done        = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0000;
      overrun_clr = (($urandom % 8) == 0);
      step();
      mg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      check("rnd_grant", 32'(grant), 32'(mg));
      check("rnd_busy", 32'(busy), 32'(|mg));
      check("rnd_tick", 32'(frame_tick), 32'(m_tick));
      check("rnd_count", 32'(frame_count), 32'(m_cnt));
      check("rnd_overrun", 32'(overrun), 32'(m_ov));
    end
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_update_arbiter.md
FRAME_UPDATE_ARBITER -- requirements
Module: frame_update_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; the grant vector width.
REQ-002 Parameter VIS_LINES, default 480: first blanking line, equal to the visible line count.
REQ-003 Parameter GRANT_TIMEOUT, default 800: maximum cycles one grant may be held.
REQ-004 clk  input  1: pixel clock; the only clock.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 hor_count  input  10: horizontal pixel counter, 0..799, from the VGA timing block.
REQ-007 ver_count  input  10: vertical line counter, 0..524, from the VGA timing block.
REQ-008 req  input  NUM_REQ: per-requester level request for a sprite-state update slot.
REQ-009 done  input  NUM_REQ: per-requester one-cycle pulse ending its slot.
REQ-010 overrun_clr  input  1: one-cycle pulse that clears overrun.
REQ-011 grant  output  NUM_REQ: registered, one-hot or zero; the granted requester may update sprite state.
REQ-012 busy  output  1: high while any grant bit is high.
REQ-013 frame_tick  output  1: one-cycle pulse at the start of vertical blanking.
REQ-014 frame_count  output  8: count of frame_tick pulses.
REQ-015 overrun  output  1: sticky flag; a grant was revoked by window close or timeout.

Function
REQ-016 The update window is open while ver_count >= VIS_LINES.
- It is closed while ver_count < VIS_LINES.
REQ-017 frame_tick is registered and pulses high for exactly one cycle.
- The pulse occurs in the cycle after the block samples ver_count==VIS_LINES and hor_count==0.
REQ-018 frame_count increments on each frame_tick and wraps from 255 to 0.
REQ-019 The FSM states are IDLE, ARB and GRANT.
REQ-020 IDLE -> ARB when the window opens. In IDLE, grant is zero.
REQ-021 ARB behaviour:
- If the window is open and any req bit is high, select one requester round-robin.
- The search starts at (last_granted+1) mod NUM_REQ.
- Assert the selected grant bit in the next cycle and enter GRANT.
- If no req bit is high, remain in ARB.
- If the window is closed, go to IDLE.
REQ-022 The round-robin pointer updates to the granted index when a grant is issued.
- The pointer resets to NUM_REQ-1, so requester 0 wins first.
REQ-023 GRANT behaviour:
- When done[g] is high for the granted index g, clear grant in the next cycle and return to ARB.
- done bits of non-granted requesters are ignored.
- The minimum gap between consecutive grants is one ARB cycle.
REQ-024 If req[g] drops while granted without done[g], the grant persists until done[g], timeout or window close.
REQ-025 If the window closes while in GRANT:
- Clear grant in the next cycle.
- Set overrun.
- Go to IDLE.
- This takes priority over a simultaneous done.
REQ-026 overrun is cleared by overrun_clr.
- A set condition in the same cycle as overrun_clr wins, leaving overrun at 1.
REQ-027 busy is combinationally equal to the OR of the grant bits.

Reset
REQ-028 While reset is high, outputs take these values immediately, independent of clk:
- grant=0, busy=0, frame_tick=0, frame_count=0, overrun=0.
- FSM in IDLE.
- Round-robin pointer at NUM_REQ-1.
- Timeout counter at 0.
REQ-029 Reset asserted mid-grant revokes the grant without setting overrun.
REQ-030 After reset release, the first frame_tick occurs only at the next ver_count==VIS_LINES, hor_count==0.

Configuration
REQ-031 Macro FRAME_UPDATE_TIMEOUT_EN controls the grant timeout.
REQ-032 With the macro defined:
- A counter clears on entry to GRANT and increments each GRANT cycle.
- If it reaches GRANT_TIMEOUT-1 without done, grant clears in the next cycle, overrun sets, and the FSM returns to ARB.
REQ-033 With the macro undefined:
- No counter is built.
- A grant ends only on done or window close.

Verification
REQ-034 Counters at ver_count=480, hor_count=0 -> frame_tick high for one cycle; frame_count 0->1; after 256 frames frame_count reads 0.
REQ-035 Window open, req=4'b1111, each grantee pulses done 3 cycles after grant -> grant order 0001, 0010, 0100, 1000, 0001, with one zero-grant cycle between grants.
REQ-036 req=4'b0100 granted, done=4'b0001 pulsed -> grant stays 0100; done=4'b0100 -> grant 0000 in the next cycle.
REQ-037 Grant held when ver_count wraps 524->0 -> grant 0000 next cycle, overrun=1, FSM IDLE; overrun_clr coincident with a new overrun -> overrun stays 1.
REQ-038 FRAME_UPDATE_TIMEOUT_EN defined, GRANT_TIMEOUT=800, done never pulsed -> grant clears after 800 grant cycles and overrun=1; macro undefined -> grant held until window close.
REQ-039 reset pulsed mid-grant -> grant=0 and overrun=0 asynchronously; after release with req=4'b1010 in an open window -> requester 1 is granted first.
